// File: rtl/weight_tile_loader.sv
// Weight tile loader: buffers ROWS input rows, then shifts them
// bottom-row-first into a PE column chain under a registered w_en.
module weight_tile_loader #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              wr_valid,
    input  logic [COLS*8-1:0] wr_data,
    output logic              wr_ready,
    output logic              w_en,
    output logic [COLS*8-1:0] weight_out,
    output logic              busy,
    output logic              done
);

    localparam int W  = COLS * 8;
    localparam int CW = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] row_cnt;
    logic [CW-1:0] shift_cnt;
    logic [W-1:0]  tile [ROWS];

    logic accept;
    logic last_row;
    logic last_shift;

    assign accept     = (state == FILL) && wr_valid;
    assign last_row   = (row_cnt == CW'(ROWS - 1));
    assign last_shift = (shift_cnt == CW'(ROWS - 1));

    assign wr_ready = (state == FILL);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = FILL;
            FILL:  if (accept && last_row) state_nx = SHIFT;
            SHIFT: if (last_shift) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            row_cnt    <= '0;
            shift_cnt  <= '0;
            w_en       <= 1'b0;
            weight_out <= '0;
            for (int i = 0; i < ROWS; i++) begin
                tile[i] <= '0;
            end
        end else begin
            state <= state_nx;

            if (state == IDLE && start) begin
                row_cnt <= '0;
            end else if (accept) begin
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end

            if (accept) begin
                tile[row_cnt] <= wr_data;
            end

            if (accept && last_row) begin
                shift_cnt <= '0;
            end else if (state == SHIFT && !last_shift) begin
                shift_cnt <= shift_cnt + 1'b1;
            end

            // Bottom row bypasses the buffer so w_en starts right after the last handshake.
            if (accept && last_row) begin
                w_en       <= 1'b1;
                weight_out <= wr_data;
            end else if (state == SHIFT && !last_shift) begin
                w_en       <= 1'b1;
                weight_out <= tile[CW'(ROWS - 2) - shift_cnt];
            end else begin
                w_en       <= 1'b0;
                weight_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_weight_tile_loader.sv
// Randomized self-checking bench for weight_tile_loader (ROWS=COLS=4)
// with a shifting PE-column reference model.
module tb_weight_tile_loader;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        w_en;
    logic [31:0] weight_out;
    logic        busy;
    logic        done;

    weight_tile_loader #(.ROWS(4), .COLS(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .w_en      (w_en),
        .weight_out(weight_out),
        .busy      (busy),
        .done      (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vecs;
    int errs;

    logic [31:0] rows [4];
    int          gaps [4];

    logic [31:0] cap_seq [$];
    logic [31:0] pe [4];
    int          cap_done;
    int          hs_last;
    int          wen_first;
    int          wen_last;
    int          done_cyc;
    int          zero_bad;
    bit          busy_after;
    bit          timeout;
    logic [4:0]  rst_obs;

    // Drives one tile load and records what the array would see.
    task automatic run_load(input bit noise, input int abort_at);
        int n;
        int gap;
        bit prev_busy;
        bit prev_done;
        cap_seq.delete();
        for (int r = 0; r < 4; r++) pe[r] = '0;
        cap_done   = 0;
        hs_last    = -1;
        wen_first  = -1;
        wen_last   = -1;
        done_cyc   = -1;
        zero_bad   = 0;
        busy_after = 1'b1;
        timeout    = 1'b1;
        rst_obs    = '1;
        n          = 0;
        gap        = 0;
        prev_busy  = 1'b0;
        prev_done  = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(posedge CLK);
            #1;
            start = (cyc == 0) || (noise && prev_busy && !prev_done);
            if (cyc > 0 && n < 4 && gap == 0) begin
                wr_valid = 1'b1;
                wr_data  = rows[n];
            end else begin
                wr_valid = (n >= 4) ? 1'($urandom) : 1'b0;
                wr_data  = $urandom;
                if (gap > 0) gap--;
            end
            @(negedge CLK);
            if (w_en) begin
                cap_seq.push_back(weight_out);
                if (wen_first < 0) wen_first = cyc;
                wen_last = cyc;
                for (int r = 3; r > 0; r--) pe[r] = pe[r-1];
                pe[0] = weight_out;
            end else if (weight_out !== 32'h0) begin
                zero_bad++;
            end
            if (done) begin
                cap_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (wr_valid && wr_ready && n < 4) begin
                n++;
                if (n == 4) hs_last = cyc;
                else gap = gaps[n-1];
            end
            if (abort_at >= 0 && cap_seq.size() == abort_at) begin
                RESET = 1'b0;
                #1;
                rst_obs = {w_en, |weight_out, busy, done, wr_ready};
                timeout = 1'b0;
                break;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            if (done_cyc >= 0 && cyc == done_cyc + 4) begin
                timeout = 1'b0;
                break;
            end
            prev_busy = busy;
            prev_done = done;
        end
        start    = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        vecs++;
        if ({w_en, weight_out, busy, done, wr_ready} !== 36'h0) begin
            errs++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {w_en, weight_out, busy, done, wr_ready});
        end
        start = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_holds_idle busy=%b exp=0", busy);
        end
        RESET = 1'b1;
        start = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            vecs++;
            if ({busy, wr_ready, w_en, done} !== 4'b0) begin
                errs++;
                $display("FAIL idle_after_reset got=%b exp=0000",
                         {busy, wr_ready, w_en, done});
            end
        end
    endtask

    task automatic test_basic;
        logic [31:0] got;
        rows = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        gaps = '{0, 0, 0, 0};
        run_load(1'b0, -1);
        vecs++;
        if (timeout !== 1'b0) begin
            errs++;
            $display("FAIL basic_timeout got=%b exp=0", timeout);
        end
        vecs++;
        if (cap_seq.size() != 4) begin
            errs++;
            $display("FAIL basic_wen_len got=%0d exp=4", cap_seq.size());
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < cap_seq.size()) ? cap_seq[k] : 32'hxxxxxxxx;
            vecs++;
            if (got !== rows[3-k]) begin
                errs++;
                $display("FAIL basic_word%0d got=%h exp=%h", k, got, rows[3-k]);
            end
        end
        vecs++;
        if (wen_first != hs_last + 1 || wen_last != wen_first + 3) begin
            errs++;
            $display("FAIL basic_wen_timing got=%0d..%0d exp=%0d..%0d",
                     wen_first, wen_last, hs_last + 1, hs_last + 4);
        end
        vecs++;
        if (cap_done != 1 || done_cyc != wen_last + 1) begin
            errs++;
            $display("FAIL basic_done got=%0d@%0d exp=1@%0d",
                     cap_done, done_cyc, wen_last + 1);
        end
        vecs++;
        if (zero_bad != 0 || busy_after !== 1'b0) begin
            errs++;
            $display("FAIL basic_idle got=zero_bad%0d busy%b exp=0,0",
                     zero_bad, busy_after);
        end
    endtask

    task automatic test_gaps;
        logic [31:0] got;
        rows = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        gaps = '{0, 3, 0, 0};
        run_load(1'b0, -1);
        for (int k = 0; k < 4; k++) begin
            got = (k < cap_seq.size()) ? cap_seq[k] : 32'hxxxxxxxx;
            vecs++;
            if (got !== rows[3-k]) begin
                errs++;
                $display("FAIL gaps_word%0d got=%h exp=%h", k, got, rows[3-k]);
            end
        end
        vecs++;
        if (cap_seq.size() != 4 || wen_first != hs_last + 1 || cap_done != 1) begin
            errs++;
            $display("FAIL gaps_timing got=len%0d first%0d done%0d exp=4,%0d,1",
                     cap_seq.size(), wen_first, cap_done, hs_last + 1);
        end
    endtask

    task automatic test_ignored_start;
        logic [31:0] got;
        rows = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        gaps = '{1, 0, 2, 0};
        run_load(1'b1, -1);
        vecs++;
        if (cap_done != 1 || busy_after !== 1'b0 || timeout !== 1'b0) begin
            errs++;
            $display("FAIL ign_start got=done%0d busy%b to%b exp=1,0,0",
                     cap_done, busy_after, timeout);
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < cap_seq.size()) ? cap_seq[k] : 32'hxxxxxxxx;
            vecs++;
            if (got !== rows[3-k]) begin
                errs++;
                $display("FAIL ign_word%0d got=%h exp=%h", k, got, rows[3-k]);
            end
        end
    endtask

    task automatic test_signed;
        logic [31:0] got;
        rows = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
        gaps = '{0, 0, 0, 0};
        run_load(1'b0, -1);
        vecs++;
        if (cap_seq.size() != 4) begin
            errs++;
            $display("FAIL signed_len got=%0d exp=4", cap_seq.size());
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < cap_seq.size()) ? cap_seq[k] : 32'hxxxxxxxx;
            vecs++;
            if (got !== 32'h80FF7F01) begin
                errs++;
                $display("FAIL signed_word%0d got=%h exp=80ff7f01", k, got);
            end
        end
    endtask

    task automatic test_reset_mid_shift;
        rows = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4};
        gaps = '{0, 0, 0, 0};
        run_load(1'b0, 2);
        vecs++;
        if (rst_obs !== 5'b0 || cap_done != 0) begin
            errs++;
            $display("FAIL midshift_reset got=%b done%0d exp=00000,0",
                     rst_obs, cap_done);
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            vecs++;
            if ({busy, done, w_en} !== 3'b0) begin
                errs++;
                $display("FAIL midshift_idle got=%b exp=000", {busy, done, w_en});
            end
        end
        rows = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        run_load(1'b0, -1);
        for (int r = 0; r < 4; r++) begin
            vecs++;
            if (pe[r] !== rows[r]) begin
                errs++;
                $display("FAIL reload_pe%0d got=%h exp=%h", r, pe[r], rows[r]);
            end
        end
        vecs++;
        if (cap_done != 1) begin
            errs++;
            $display("FAIL reload_done got=%0d exp=1", cap_done);
        end
    endtask

    // Loaded tile must land with PE row r holding tile row r.
    task automatic test_random;
        for (int t = 0; t < 12; t++) begin
            for (int r = 0; r < 4; r++) begin
                rows[r] = $urandom;
                gaps[r] = $urandom_range(0, 3);
            end
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            run_load(t[0], -1);
            for (int r = 0; r < 4; r++) begin
                vecs++;
                if (pe[r] !== rows[r]) begin
                    errs++;
                    $display("FAIL rand%0d_pe%0d got=%h exp=%h", t, r, pe[r], rows[r]);
                end
            end
            vecs++;
            if (cap_seq.size() != 4 || cap_done != 1 || zero_bad != 0
                || wen_first != hs_last + 1 || done_cyc != wen_last + 1) begin
                errs++;
                $display("FAIL rand%0d_timing got=len%0d done%0d zb%0d f%0d d%0d exp=4,1,0,%0d,%0d",
                         t, cap_seq.size(), cap_done, zero_bad, wen_first,
                         done_cyc, hs_last + 1, hs_last + 5);
            end
        end
    endtask

    initial begin
        vecs     = 0;
        errs     = 0;
        RESET    = 1'b0;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        test_reset;
        test_basic;
        test_gaps;
        test_ignored_start;
        test_signed;
        test_reset_mid_shift;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=stalled exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/weight_tile_loader.md
WEIGHT_TILE_LOADER -- requirements
Module: weight_tile_loader

Interface
REQ-001 Parameter ROWS, default 4, number of PE rows in the array column chain (>=2).
REQ-002 Parameter COLS, default 4, number of PE columns fed in parallel (>=1).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin one tile load; honoured only in IDLE.
REQ-006 wr_valid  input  1  upstream row word valid.
REQ-007 wr_data  input  COLS*8  one weight row, column c in bits [8c+7:8c], signed int8, row 0 (top) sent first.
REQ-008 wr_ready  output  1  loader can accept wr_data this cycle.
REQ-009 w_en  output  1  weight-load enable to every PE in the array.
REQ-010 weight_out  output  COLS*8  weight word to the top PE of each column, same column packing as wr_data.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on tile-load completion.

Function
REQ-013 The block SHALL implement the states IDLE, FILL, SHIFT and DONE, held in a registered state variable.
REQ-014 IDLE: start=1 SHALL move to FILL on the next edge with the row counter at 0; start in any other state SHALL be ignored.
REQ-015 FILL: wr_ready SHALL be 1; wr_ready SHALL be 0 in IDLE, SHIFT and DONE.
REQ-016 FILL: each cycle with wr_valid=1 and wr_ready=1 SHALL write wr_data into tile buffer entry row_cnt and increment row_cnt; cycles with wr_valid=0 SHALL change nothing.
REQ-017 The handshake accepting row ROWS-1 SHALL move FILL to SHIFT on the same edge, with the shift counter at 0.
REQ-018 SHIFT SHALL last exactly ROWS cycles, then move to DONE.
REQ-019 w_en and weight_out SHALL be registered outputs: w_en=1 for exactly ROWS consecutive cycles, the first being the cycle after the final FILL handshake.
REQ-020 During the k-th w_en cycle (k=0..ROWS-1), weight_out SHALL equal buffer row ROWS-1-k (bottom row first), so that after ROWS vertical shifts PE row r holds buffer row r.
REQ-021 Whenever w_en=0, weight_out SHALL be 0.
REQ-022 DONE SHALL last one cycle with done=1 and w_en=0, then return to IDLE; done SHALL be 0 at all other times.
REQ-023 start asserted in DONE SHALL be ignored; a new load SHALL require start in IDLE, giving at least one IDLE cycle between tiles.
REQ-024 Weight data SHALL pass through unmodified (no sign extension or arithmetic); buffer width is ROWS x COLS x 8 bits.
REQ-025 The external array SHALL hold EN=1 throughout w_en=1; the loader does not drive EN.
REQ-026 Buffer contents after DONE SHALL be retained until overwritten by the next FILL; they have no effect on outputs while idle.

Reset
REQ-027 RESET=0 SHALL immediately, without a clock, set state=IDLE, row/shift counters=0, w_en=0, weight_out=0, busy=0, done=0, wr_ready=0, and clear the tile buffer.
REQ-028 RESET asserted mid-FILL or mid-SHIFT SHALL abort the load; after release the block SHALL sit in IDLE until start.
REQ-029 The first edge after RESET deassertion SHALL be treated as a normal IDLE cycle (start sampled).

Verification (ROWS=COLS=4)
REQ-030 Basic load: start, then rows 0..3 = 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D on back-to-back cycles -> w_en high 4 cycles with weight_out 0x100F0E0D, 0x0C0B0A09, 0x08070605, 0x04030201; done pulses the next cycle; busy falls with return to IDLE.
REQ-031 Backpressure/gaps: wr_valid deasserted 3 cycles between rows 1 and 2 -> no extra buffer writes, row_cnt holds at 2, output sequence identical to REQ-030.
REQ-032 Ignored start: start pulsed in FILL, SHIFT and DONE -> no restart, counters unaffected, exactly one done pulse.
REQ-033 Signed data: all rows 0x80FF7F01 -> weight_out 0x80FF7F01 each of the 4 w_en cycles, bits unchanged.
REQ-034 Reset mid-SHIFT: RESET low during the second w_en cycle -> w_en, weight_out, busy and done 0 immediately; no done pulse; subsequent start plus 4 rows reproduces REQ-030.
REQ-035 End-to-end: loader driving a 4x4 PE column array, then W_EN=0 compute -> PE row r weight equals row r of the loaded tile for all r, c.
